// File: rtl/adder_error_monitor.sv
// rtl/adder_error_monitor.sv - streaming error-metric accumulator for approximate adder results
//
// Purpose: accepts operand pairs together with an approximate adder's {Cout,S} result,
// recomputes the exact sum, and accumulates sample count, error count, maximum absolute
// error and a saturating sum of absolute errors over a run of num_samples samples.
// Three-stage pipeline: S1 exact sum, S2 absolute difference, S3 metric update.
//
// Optional feature macro: HAMMING_DIST_EN adds output ham_sum, a saturating sum of the
// popcount of (dut_res ^ exact) per sample.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   start, num_samples          run start pulse and sample count latched on accepted start
//   in_valid, in_ready          sample handshake (op_a, op_b, cin, dut_res)
//   busy, done                  run in progress / run complete (level)
//   sample_count, err_count     samples accumulated / samples with a nonzero error
//   max_err, sum_err            largest absolute error / saturating sum of absolute errors
//   ham_sum                     (HAMMING_DIST_EN only) saturating sum of bit-error counts
module adder_error_monitor #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic [WIDTH:0]   dut_res,
    output logic             busy,
    output logic             done,
    output logic [31:0]      sample_count,
    output logic [31:0]      err_count,
    output logic [WIDTH:0]   max_err,
    output logic [ACC_W-1:0] sum_err
`ifdef HAMMING_DIST_EN
    ,
    output logic [ACC_W-1:0] ham_sum
`endif
);
    localparam int RW = WIDTH + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     num_q, num_d;
    logic [31:0]     acc_q, acc_d;

    logic            s1_valid_q, s1_valid_d;
    logic [RW-1:0]   s1_exact_q, s1_exact_d;
    logic [RW-1:0]   s1_res_q, s1_res_d;
    logic            s2_valid_q, s2_valid_d;
    logic [RW-1:0]   s2_diff_q, s2_diff_d;

    logic [31:0]     sample_q, sample_d;
    logic [31:0]     err_q, err_d;
    logic [RW-1:0]   max_q, max_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W:0]  sum_ext;

    logic            xfer;
    logic            clear;

    assign in_ready = (state_q == ST_RUN) && (acc_q < num_q);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);

    assign sample_count = sample_q;
    assign err_count    = err_q;
    assign max_err      = max_q;
    assign sum_err      = sum_q;

    // Run control. Metrics are only cleared from IDLE/DONE, where the pipeline is
    // already empty, so a clear can never collide with an S3 update.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        acc_d   = acc_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d   = num_samples;
                    acc_d   = 32'd0;
                    clear   = 1'b1;
                    state_d = (num_samples == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    acc_d = acc_q + 32'd1;
                    if (acc_q + 32'd1 == num_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // S1/S2 datapath
    always_comb begin
        s1_valid_d = xfer;
        s1_exact_d = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
        s1_res_d   = dut_res;
        s2_valid_d = s1_valid_q;
        // Unsigned magnitude of the error, never wrapping.
        s2_diff_d  = (s1_res_q >= s1_exact_q) ? (s1_res_q - s1_exact_q)
                                              : (s1_exact_q - s1_res_q);
    end

    // S3 metric update
    always_comb begin
        sample_d = sample_q;
        err_d    = err_q;
        max_d    = max_q;
        sum_d    = sum_q;
        sum_ext  = {1'b0, sum_q} + {{(ACC_W + 1 - RW){1'b0}}, s2_diff_q};
        if (clear) begin
            sample_d = '0;
            err_d    = '0;
            max_d    = '0;
            sum_d    = '0;
        end else if (s2_valid_q) begin
            sample_d = sample_q + 32'd1;
            if ((s2_diff_q != '0) && (err_q != '1)) begin
                err_d = err_q + 32'd1;
            end
            if (s2_diff_q > max_q) begin
                max_d = s2_diff_q;
            end
            sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_exact_q <= '0;
            s1_res_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_diff_q  <= '0;
            sample_q   <= '0;
            err_q      <= '0;
            max_q      <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            acc_q      <= acc_d;
            s1_valid_q <= s1_valid_d;
            s1_exact_q <= s1_exact_d;
            s1_res_q   <= s1_res_d;
            s2_valid_q <= s2_valid_d;
            s2_diff_q  <= s2_diff_d;
            sample_q   <= sample_d;
            err_q      <= err_d;
            max_q      <= max_d;
            sum_q      <= sum_d;
        end
    end

`ifdef HAMMING_DIST_EN
    localparam int HW = $clog2(RW + 1);

    logic [HW-1:0]    s2_ham_q, s2_ham_d;
    logic [RW-1:0]    s1_xor;
    logic [ACC_W-1:0] ham_q, ham_d;
    logic [ACC_W:0]   ham_ext;

    assign s1_xor  = s1_res_q ^ s1_exact_q;
    assign ham_sum = ham_q;

    always_comb begin
        s2_ham_d = '0;
        for (int i = 0; i < RW; i++) begin
            s2_ham_d = s2_ham_d + HW'(s1_xor[i]);
        end
    end

    always_comb begin
        ham_d   = ham_q;
        ham_ext = {1'b0, ham_q} + {{(ACC_W + 1 - HW){1'b0}}, s2_ham_q};
        if (clear) begin
            ham_d = '0;
        end else if (s2_valid_q) begin
            ham_d = ham_ext[ACC_W] ? '1 : ham_ext[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_ham_q <= '0;
            ham_q    <= '0;
        end else begin
            s2_ham_q <= s2_ham_d;
            ham_q    <= ham_d;
        end
    end
`endif

endmodule

// File: tb/tb_adder_error_monitor.sv
// tb/tb_adder_error_monitor.sv - randomized run-level model check of adder_error_monitor
`timescale 1ns/1ps
module tb_adder_error_monitor;
    localparam int WIDTH = 16;
    localparam int ACC_W = 20;
    localparam int RW    = WIDTH + 1;
    localparam longint SAT = (64'sd1 <<< ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      num_samples = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             cin = 1'b0;
    logic [RW-1:0]    dut_res = '0;
    logic             busy;
    logic             done;
    logic [31:0]      sample_count;
    logic [31:0]      err_count;
    logic [RW-1:0]    max_err;
    logic [ACC_W-1:0] sum_err;
`ifdef HAMMING_DIST_EN
    logic [ACC_W-1:0] ham_sum;
`endif

    adder_error_monitor #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .cin(cin), .dut_res(dut_res), .busy(busy), .done(done),
        .sample_count(sample_count), .err_count(err_count),
        .max_err(max_err), .sum_err(sum_err)
`ifdef HAMMING_DIST_EN
        , .ham_sum(ham_sum)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            n_err++;
        end
    endtask

    // ---------------- run-level reference model ----------------
    typedef struct { longint cyc; longint diff; longint ham; } pend_t;
    pend_t  pend[$];
    longint cyc = 0;
    longint done_cyc = -1;
    bit     m_busy = 0;
    bit     m_seen_rst = 0;
    longint m_num = 0, m_acc = 0;
    longint e_sample = 0, e_err = 0, e_max = 0, e_sum = 0, e_ham = 0;
    bit     e_done = 0;
    logic [RW-1:0] m_exact;
    longint m_diff;
    pend_t  m_p;
    bit     m_was_busy;

    always @(posedge clk) begin
        cyc++;
        while (pend.size() > 0 && pend[0].cyc == cyc) begin
            m_p = pend.pop_front();
            e_sample++;
            if (m_p.diff != 0 && e_err < 64'hFFFF_FFFF) e_err++;
            if (m_p.diff > e_max) e_max = m_p.diff;
            e_sum = e_sum + m_p.diff;
            if (e_sum > SAT) e_sum = SAT;
            e_ham = e_ham + m_p.ham;
            if (e_ham > SAT) e_ham = SAT;
        end
        if (rst) begin
            pend.delete();
            m_busy = 0; m_num = 0; m_acc = 0; done_cyc = -1;
            e_sample = 0; e_err = 0; e_max = 0; e_sum = 0; e_ham = 0; e_done = 0;
            m_seen_rst = 1;
        end else begin
            m_was_busy = m_busy;
            if (m_was_busy && m_acc < m_num && in_valid) begin
                m_exact = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
                m_diff  = (dut_res >= m_exact) ? longint'(dut_res - m_exact)
                                               : longint'(m_exact - dut_res);
                pend.push_back('{cyc + 2, m_diff, longint'($countones(dut_res ^ m_exact))});
                m_acc++;
                if (m_acc == m_num) done_cyc = cyc + 3;
            end
            if (!m_was_busy && start) begin
                e_sample = 0; e_err = 0; e_max = 0; e_sum = 0; e_ham = 0;
                m_num = longint'(num_samples);
                m_acc = 0;
                e_done = (num_samples == 0);
                m_busy = (num_samples != 0);
            end
            if (cyc == done_cyc) begin
                e_done = 1;
                m_busy = 0;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (m_seen_rst) begin
            n_vec++;
            chk("in_ready", 64'(in_ready), 64'(m_busy && m_acc < m_num));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("sample_count", 64'(sample_count), e_sample);
            chk("err_count", 64'(err_count), e_err);
            chk("max_err", 64'(max_err), e_max);
            chk("sum_err", 64'(sum_err), e_sum);
`ifdef HAMMING_DIST_EN
            chk("ham_sum", 64'(ham_sum), e_ham);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        num_samples = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [RW-1:0] r);
        bit got;
        got = 0;
        op_a = a; op_b = b; cin = c; dut_res = r; in_valid = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!got) begin
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 40 cycles");
            n_err++;
        end
    endtask

    task automatic send_rand(input int mode);
        logic [WIDTH-1:0] a, b;
        logic c;
        logic [RW-1:0] ex, r;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        c = 1'($urandom);
        ex = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        case (mode)
            0: r = ex;
            1: r = ($urandom_range(0, 1) == 1) ? ex + RW'($urandom_range(0, 9))
                                               : ex - RW'($urandom_range(0, 9));
            default: r = RW'($urandom);
        endcase
        send(a, b, c, r);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic wait_done(input int limit);
        bit seen;
        seen = 0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            $display("FAIL done_timeout: got done=0 expected 1 within %0d cycles", limit);
            n_err++;
        end
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sample_count", 64'(sample_count), 64'd0);
        rst = 1'b0;
        tick();

        // exact DUT, 4 samples; start pulsed mid-run must be ignored
        do_start(4);
        send_rand(0);
        send_rand(0);
        do_start(7);
        send_rand(0);
        send_rand(0);
        wait_done(20);
        chk("exact_sample_count", 64'(sample_count), 64'd4);
        chk("exact_err_count", 64'(err_count), 64'd0);
        chk("exact_sum_err", 64'(sum_err), 64'd0);

        // carry-out dropped: 0xFFFF + 1 reported as 0
        do_start(1);
        send(16'hFFFF, 16'h0001, 1'b0, 17'h00000);
        wait_done(20);
        chk("cout_err_count", 64'(err_count), 64'd1);
        chk("cout_max_err", 64'(max_err), 64'h10000);
        chk("cout_sum_err", 64'(sum_err), 64'd65536);
`ifdef HAMMING_DIST_EN
        chk("cout_ham_sum", 64'(ham_sum), 64'd1);
`endif

        // diffs 3 (below), 7 (above), 2 (below)
        do_start(3);
        send(16'd100, 16'd0, 1'b0, 17'd97);
        send(16'd100, 16'd0, 1'b0, 17'd107);
        send(16'd50, 16'd49, 1'b1, 17'd98);
        wait_done(20);
        chk("three_err_count", 64'(err_count), 64'd3);
        chk("three_max_err", 64'(max_err), 64'd7);
        chk("three_sum_err", 64'(sum_err), 64'd12);

        // in_valid toggling with num_samples=2, then valid held past the end
        do_start(2);
        send_rand(1);
        tick();
        send_rand(1);
        in_valid = 1'b1;
        repeat (6) tick();
        chk("toggle_sample_count", 64'(sample_count), 64'd2);
        chk("toggle_done", 64'(done), 64'd1);
        // start while in_valid is high in DONE: start wins, no sample taken
        do_start(0);
        in_valid = 1'b0;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_sample_count", 64'(sample_count), 64'd0);
        chk("zero_in_ready", 64'(in_ready), 64'd0);

        // reset in the middle of a run
        do_start(10);
        repeat (5) send_rand(2);
        rst = 1'b1;
        tick();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_sample_count", 64'(sample_count), 64'd0);
        rst = 1'b0;
        tick();
        do_start(1);
        send_rand(1);
        wait_done(20);
        chk("after_rst_sample_count", 64'(sample_count), 64'd1);

        // sum_err saturation (ACC_W=20): 10 x 0x1FFFF exceeds 2^20-1
        do_start(10);
        repeat (10) send(16'd0, 16'd0, 1'b0, 17'h1FFFF);
        wait_done(20);
        chk("sat_sum_err", 64'(sum_err), 64'hFFFFF);
        chk("sat_max_err", 64'(max_err), 64'h1FFFF);
        chk("sat_err_count", 64'(err_count), 64'd10);

        // random runs
        for (int run = 0; run < 25; run++) begin
            int n, mode;
            n = $urandom_range(1, 12);
            mode = $urandom_range(0, 2);
            do_start(n);
            for (int s = 0; s < n; s++) send_rand(mode);
            wait_done(20);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
